// File: rtl/bb_pkg.sv
// rtl/bb_pkg.sv - shared types for the baseball scorer
package bb_pkg;

    typedef enum logic [2:0] {
        ACT_WALK   = 3'd0,
        ACT_SINGLE = 3'd1,
        ACT_DOUBLE = 3'd2,
        ACT_TRIPLE = 3'd3,
        ACT_HR     = 3'd4,
        ACT_BUNT   = 3'd5,
        ACT_GROUND = 3'd6,
        ACT_FLY    = 3'd7
    } action_e;

    typedef enum logic [1:0] {
        RES_A    = 2'd0,
        RES_B    = 2'd1,
        RES_DRAW = 2'd2
    } result_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_CALC = 2'd2,
        S_OUT  = 2'd3
    } state_e;

    // number of occupied bases in a 3-bit occupancy vector
    function automatic logic [2:0] popcount3(input logic [2:0] v);
        return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]};
    endfunction

endpackage

// File: rtl/bb_base_adv.sv
// rtl/bb_base_adv.sv - combinational runner advance for one play
module bb_base_adv
    import bb_pkg::*;
(
    input  logic [2:0] bases_i,     // bit0 = 1st, bit1 = 2nd, bit2 = 3rd
    input  logic [1:0] outs_i,      // outs before the play (0..2)
    input  action_e    action_i,
    output logic [2:0] bases_o,
    output logic [2:0] runs_o,
    output logic [1:0] outs_add_o
);

    logic [2:0] nb;
    logic [2:0] raw_runs;
    logic [2:0] outs_total;

    // per-action runner movement, runs before the third-out rule
    always_comb begin
        nb         = bases_i;
        raw_runs   = 3'd0;
        outs_add_o = 2'd0;
        case (action_i)
            ACT_WALK: begin
                nb       = {bases_i[2] | (bases_i[1] & bases_i[0]), bases_i[1] | bases_i[0], 1'b1};
                raw_runs = {2'b00, &bases_i};
            end
            ACT_SINGLE: begin
                nb       = {bases_i[1:0], 1'b1};
                raw_runs = {2'b00, bases_i[2]};
            end
            ACT_DOUBLE: begin
                nb       = {bases_i[0], 2'b10};
                raw_runs = popcount3({1'b0, bases_i[2:1]});
            end
            ACT_TRIPLE: begin
                nb       = 3'b100;
                raw_runs = popcount3(bases_i);
            end
            ACT_HR: begin
                nb       = 3'b000;
                raw_runs = popcount3(bases_i) + 3'd1;
            end
            ACT_BUNT: begin
                nb         = {bases_i[1:0], 1'b0};
                raw_runs   = {2'b00, bases_i[2]};
                outs_add_o = 2'd1;
            end
            ACT_GROUND: begin
                // with two out the batter alone ends the half
                nb         = {bases_i[1], 2'b00};
                raw_runs   = {2'b00, bases_i[2]};
                outs_add_o = (bases_i[0] && outs_i != 2'd2) ? 2'd2 : 2'd1;
            end
            ACT_FLY: begin
                nb         = {1'b0, bases_i[1:0]};
                raw_runs   = {2'b00, bases_i[2]};
                outs_add_o = 2'd1;
            end
            default: ;
        endcase
    end

    assign outs_total = {1'b0, outs_i} + {1'b0, outs_add_o};

    // a play that makes the third out scores nothing and clears the bases
    always_comb begin
        bases_o = nb;
        runs_o  = raw_runs;
        if (outs_total >= 3'd3) begin
            bases_o = 3'b000;
            runs_o  = 3'd0;
        end
    end

endmodule

// File: rtl/bb_scorer_p.sv
// rtl/bb_scorer_p.sv - parametrised baseball game scorer
module bb_scorer_p
    import bb_pkg::*;
#(
    parameter  int INNINGS = 3,
    parameter  int SCORE_W = 8,
    localparam int INN_W   = $clog2(INNINGS + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [INN_W-1:0]   inning,
    input  logic               half,
    input  logic [2:0]         action,
    output logic               out_valid,
    output logic [SCORE_W-1:0] score_A,
    output logic [SCORE_W-1:0] score_B,
    output logic [1:0]         result,
    output logic               err
);

    localparam logic [INN_W-1:0]   LAST_INN  = INN_W'(INNINGS);
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
    localparam int                 POS_W     = INN_W + 1;

    state_e             state_q, state_d;
    logic [2:0]         bases_q;
    logic [1:0]         outs_q;          // 3 marks a finished half
    logic [POS_W-1:0]   prev_pos_q;
    logic [SCORE_W-1:0] score_a_q, score_b_q;
    logic               err_q;
    result_e            result_q;

    logic               beat, bad_inning, backwards, new_half, half_over, ignore_beat;
    logic [POS_W-1:0]   pos;
    logic [2:0]         cur_bases, adv_bases, adv_runs, outs_sum;
    logic [1:0]         cur_outs, adv_outs, outs_next;
    logic [SCORE_W:0]   sum_a, sum_b;
    logic [SCORE_W-1:0] sat_a, sat_b;

    assign beat        = in_valid && (state_q == S_IDLE || state_q == S_PLAY);
    assign pos         = {inning, half};
    assign bad_inning  = (inning == '0) || (inning > LAST_INN);
    assign backwards   = pos < prev_pos_q;
    assign new_half    = pos != prev_pos_q;
    assign cur_bases   = new_half ? 3'b000 : bases_q;
    assign cur_outs    = new_half ? 2'd0 : outs_q;
    assign half_over   = cur_outs == 2'd3;
    // covers both skip-bottom and post-walk-off beats: B cannot fall behind in the last bottom
    assign ignore_beat = (inning == LAST_INN) && half && (score_b_q > score_a_q);

    bb_base_adv u_adv (
        .bases_i    (cur_bases),
        .outs_i     (cur_outs),
        .action_i   (action_e'(action)),
        .bases_o    (adv_bases),
        .runs_o     (adv_runs),
        .outs_add_o (adv_outs)
    );

    assign outs_sum  = {1'b0, cur_outs} + {1'b0, adv_outs};
    assign outs_next = (outs_sum >= 3'd3) ? 2'd3 : outs_sum[1:0];
    assign sum_a     = {1'b0, score_a_q} + (SCORE_W + 1)'(adv_runs);
    assign sum_b     = {1'b0, score_b_q} + (SCORE_W + 1)'(adv_runs);
    assign sat_a     = sum_a[SCORE_W] ? SCORE_MAX : sum_a[SCORE_W-1:0];
    assign sat_b     = sum_b[SCORE_W] ? SCORE_MAX : sum_b[SCORE_W-1:0];

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (in_valid) state_d = S_PLAY;
            S_PLAY:  if (!in_valid) state_d = S_CALC;
            S_CALC:  state_d = S_OUT;
            S_OUT:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // game state: play scoring, error capture, result latch, clear after the strobe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bases_q    <= 3'b000;
            outs_q     <= 2'd0;
            prev_pos_q <= '0;
            score_a_q  <= '0;
            score_b_q  <= '0;
            err_q      <= 1'b0;
            result_q   <= RES_A;
        end else if (state_q == S_OUT) begin
            bases_q    <= 3'b000;
            outs_q     <= 2'd0;
            prev_pos_q <= '0;
            score_a_q  <= '0;
            score_b_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            if (state_q == S_CALC) begin
                result_q <= (score_a_q > score_b_q) ? RES_A :
                            (score_b_q > score_a_q) ? RES_B : RES_DRAW;
            end
            if (beat) begin
                if (bad_inning || backwards) begin
                    err_q <= 1'b1;
                end else if (!ignore_beat) begin
                    if (half_over) begin
                        err_q <= 1'b1;
                    end else begin
                        bases_q    <= adv_bases;
                        outs_q     <= outs_next;
                        prev_pos_q <= pos;
                        if (half) score_b_q <= sat_b;
                        else      score_a_q <= sat_a;
                    end
                end
            end
        end
    end

    // outputs are visible only during the strobe
    always_comb begin
        out_valid = (state_q == S_OUT);
        score_A   = (state_q == S_OUT) ? score_a_q : '0;
        score_B   = (state_q == S_OUT) ? score_b_q : '0;
        result    = (state_q == S_OUT) ? result_q : 2'b00;
        err       = (state_q == S_OUT) ? err_q : 1'b0;
    end

endmodule

// File: tb/tb_bb_scorer_p.sv
// tb/tb_bb_scorer_p.sv - randomized self-checking bench for bb_scorer_p
module tb_bb_scorer_p;

    localparam int INNINGS = 3;
    localparam int INN_W   = $clog2(INNINGS + 1);

    typedef struct {
        int inn;
        int half;
        int act;
    } beat_t;

    logic             clk = 1'b0;
    logic             rst, in_valid, half;
    logic [INN_W-1:0] inning;
    logic [2:0]       action;

    logic       ov8, err8, ov4, err4;
    logic [7:0] sa8, sb8;
    logic [3:0] sa4, sb4;
    logic [1:0] res8, res4;

    int total = 0;
    int bad = 0;
    int edge_cnt = 0;
    int exp_edge = -1;
    int e_sa8, e_sb8, e_r8, e_e8, e_sa4, e_sb4, e_r4, e_e4;
    beat_t g[$];

    bb_scorer_p #(.INNINGS(INNINGS), .SCORE_W(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .inning(inning), .half(half),
        .action(action), .out_valid(ov8), .score_A(sa8), .score_B(sb8),
        .result(res8), .err(err8)
    );

    bb_scorer_p #(.INNINGS(INNINGS), .SCORE_W(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .inning(inning), .half(half),
        .action(action), .out_valid(ov4), .score_A(sa4), .score_B(sb4),
        .result(res4), .err(err4)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    function automatic void chk(string name, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (edge %0d)", name, act, exp, edge_cnt);
        end
    endfunction

    // game-level reference: runners as an occupancy array, plain counting
    function automatic void model(input beat_t q[$], input int sw,
                                  output int sa, output int sb, output int r, output int e);
        int sc[2];
        int occ[4];
        int outs, prev, pos, runs, add, k, mx;
        sc   = '{0, 0};
        occ  = '{0, 0, 0, 0};
        outs = 0;
        prev = 0;
        e    = 0;
        mx   = (1 << sw) - 1;
        foreach (q[i]) begin
            pos = q[i].inn * 2 + q[i].half;
            if (q[i].inn < 1 || q[i].inn > INNINGS || pos < prev) begin
                e = 1;
                continue;
            end
            if (q[i].inn == INNINGS && q[i].half == 1 && sc[1] > sc[0]) continue;
            if (pos != prev) begin
                occ  = '{0, 0, 0, 0};
                outs = 0;
                prev = pos;
            end
            if (outs >= 3) begin
                e = 1;
                continue;
            end
            runs = 0;
            add  = 0;
            case (q[i].act)
                0: begin
                    if (occ[1] != 0) begin
                        if (occ[2] != 0) begin
                            if (occ[3] != 0) runs = 1;
                            occ[3] = 1;
                        end
                        occ[2] = 1;
                    end
                    occ[1] = 1;
                end
                1, 2, 3, 5: begin
                    k = (q[i].act == 5) ? 1 : q[i].act;
                    for (int b = 3; b >= 1; b--) begin
                        if (occ[b] != 0) begin
                            occ[b] = 0;
                            if (b + k > 3) runs++;
                            else occ[b + k] = 1;
                        end
                    end
                    if (q[i].act == 5) add = 1;
                    else occ[k] = 1;
                end
                4: begin
                    runs = occ[1] + occ[2] + occ[3] + 1;
                    occ  = '{0, 0, 0, 0};
                end
                6: begin
                    if (occ[1] != 0 && outs < 2) begin
                        add    = 2;
                        occ[1] = 0;
                    end else begin
                        add = 1;
                    end
                    for (int b = 3; b >= 1; b--) begin
                        if (occ[b] != 0) begin
                            occ[b] = 0;
                            if (b == 3) runs++;
                            else occ[b + 1] = 1;
                        end
                    end
                end
                default: begin
                    add = 1;
                    if (occ[3] != 0) begin
                        runs   = 1;
                        occ[3] = 0;
                    end
                end
            endcase
            outs += add;
            if (outs >= 3) begin
                runs = 0;
                occ  = '{0, 0, 0, 0};
            end
            sc[q[i].half] = (sc[q[i].half] + runs > mx) ? mx : sc[q[i].half] + runs;
        end
        sa = sc[0];
        sb = sc[1];
        r  = (sa > sb) ? 0 : (sb > sa) ? 1 : 2;
    endfunction

    function automatic void add(int inn, int h, string s);
        for (int i = 0; i < s.len(); i++) g.push_back('{inn, h, int'(s[i]) - 48});
    endfunction

    // pin the model itself against hand-worked results
    function automatic void pin(string nm, int sw, int a, int b, int r, int e);
        int ma, mb, mr, me;
        model(g, sw, ma, mb, mr, me);
        chk({nm, " model A"}, ma, a);
        chk({nm, " model B"}, mb, b);
        chk({nm, " model result"}, mr, r);
        chk({nm, " model err"}, me, e);
    endfunction

    task automatic drive_beat(input beat_t bt);
        in_valid = 1'b1;
        inning   = INN_W'(bt.inn);
        half     = bt.half[0];
        action   = 3'(bt.act);
        @(posedge clk);
        #1;
    endtask

    task automatic run_game();
        model(g, 8, e_sa8, e_sb8, e_r8, e_e8);
        model(g, 4, e_sa4, e_sb4, e_r4, e_e4);
        foreach (g[i]) drive_beat(g[i]);
        in_valid = 1'b0;
        exp_edge = edge_cnt + 2;
        repeat (3 + $urandom_range(0, 2)) @(posedge clk);
        #1;
        g.delete();
    endtask

    // every cycle: either the expected result beat or all-zero outputs
    always @(negedge clk) begin
        if (edge_cnt == exp_edge) begin
            chk("out_valid8", int'(ov8), 1);
            chk("score_A8", int'(sa8), e_sa8);
            chk("score_B8", int'(sb8), e_sb8);
            chk("result8", int'(res8), e_r8);
            chk("err8", int'(err8), e_e8);
            chk("out_valid4", int'(ov4), 1);
            chk("score_A4", int'(sa4), e_sa4);
            chk("score_B4", int'(sb4), e_sb4);
            chk("result4", int'(res4), e_r4);
            chk("err4", int'(err4), e_e4);
        end else begin
            chk("quiet8", int'({ov8, sa8, sb8, res8, err8}), 0);
            chk("quiet4", int'({ov4, sa4, sb4, res4, err4}), 0);
        end
    end

    initial begin
        int n;
        rst      = 1'b1;
        in_valid = 1'b0;
        inning   = '0;
        half     = 1'b0;
        action   = 3'd0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (100) @(posedge clk);
        #1;

        // bases-loaded walk forces one in; first fly scores the runner from third
        add(1, 0, "0000777"); add(1, 1, "777");
        pin("walk", 8, 2, 0, 0, 0);
        run_game();

        // double play ends nothing on the board; sac fly scores B
        add(1, 0, "167"); add(1, 1, "3777");
        pin("outplay", 8, 0, 1, 1, 0);
        run_game();

        // walk-off: second homer ignored
        add(1, 0, "4777"); add(3, 1, "244");
        pin("walkoff", 8, 1, 2, 1, 0);
        run_game();

        // skip-bottom: B already ahead
        add(1, 1, "44"); add(3, 0, "777"); add(3, 1, "44");
        pin("skip", 8, 0, 2, 1, 0);
        run_game();

        add(1, 0, "777"); add(1, 1, "777");
        pin("draw", 8, 0, 0, 2, 0);
        run_game();

        for (int i = 0; i < 5; i++) add(1, 0, "1114");
        pin("sat8", 8, 20, 0, 0, 0);
        pin("sat4", 4, 15, 0, 0, 0);
        run_game();

        add(1, 0, "4"); add(0, 0, "4");
        pin("inning0", 8, 1, 0, 0, 1);
        run_game();

        add(1, 0, "7774");
        pin("after3rd", 8, 0, 0, 2, 1);
        run_game();

        // err must not leak into this game
        add(1, 0, "777"); add(1, 1, "777");
        run_game();

        // reset mid-burst: no strobe, then a clean game
        add(1, 0, "1234");
        for (int i = 0; i < 3; i++) drive_beat(g[i]);
        rst      = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        g.delete();
        repeat (4) @(posedge clk);
        #1;
        add(1, 0, "167"); add(1, 1, "3777");
        run_game();

        for (int gm = 0; gm < 150; gm++) begin
            for (int inn = 1; inn <= INNINGS; inn++) begin
                for (int h = 0; h < 2; h++) begin
                    if ($urandom_range(0, 7) == 0) continue;
                    n = $urandom_range(1, 9);
                    for (int p = 0; p < n; p++) begin
                        if ($urandom_range(0, 40) == 0)
                            g.push_back('{0, int'($urandom_range(0, 1)), int'($urandom_range(0, 7))});
                        else
                            g.push_back('{inn, h, int'($urandom_range(0, 7))});
                    end
                end
            end
            if (g.size() == 0) add(1, 0, "4");
            run_game();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
